// File: rtl/vam_pkg.sv
// ============================================================================
// Module      : vam_pkg
// Description : Shared types and constants for the VAM-16 round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vam_pkg;

    localparam int VAM_OPND_W    = 16;
    localparam int VAM_DATA_W    = 32;
    localparam int VAM_N_REQ_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
    } vam_state_t;

endpackage

`default_nettype wire

// File: rtl/vam_rr_picker.sv
// ============================================================================
// Module      : vam_rr_picker
// Description : Combinational round-robin pick: first valid index at or after
//               ptr_i, wrapping around the request vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vam_rr_picker
    import vam_pkg::*;
#(
    parameter int N_REQ = VAM_N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
    output logic                     any_o
);

    localparam int IDX_W = $clog2(N_REQ);

    // Scan from the farthest offset down so the nearest valid one wins last.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = |req_i;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N_REQ]) begin
                gnt_idx_o = IDX_W'((int'(ptr_i) + i) % N_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vam_rr_arbiter.sv
// ============================================================================
// Module      : vam_rr_arbiter
// Description : Round-robin arbiter sharing one VAM-16 multiplier among N_REQ
//               requesters. Optional WAIT watchdog: VAM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vam_rr_arbiter
    import vam_pkg::*;
#(
    parameter int N_REQ       = VAM_N_REQ_DEF,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*VAM_DATA_W-1:0]  req_opnd,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(N_REQ)-1:0]     rsp_id,
    output logic [VAM_DATA_W-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic                         vam_start,
    output logic [VAM_DATA_W-1:0]        vam_bus32,
    input  logic                         vam_ready,
    input  logic [VAM_DATA_W-1:0]        vam_rslt,
    output logic                         busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int SCNT_W = $clog2(START_CYC + 1);

    vam_state_t              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        gnt_q, gnt_d;
    logic [VAM_DATA_W-1:0]   opnd_q, opnd_d;
    logic [VAM_DATA_W-1:0]   data_q, data_d;
    logic [SCNT_W-1:0]       scnt_q, scnt_d;
    logic                    vrdy_prev_q;

    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;

`ifdef VAM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    err_q, err_d;
`else
    logic                    unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    vam_rr_picker #(
        .N_REQ     (N_REQ)
    ) u_picker (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        opnd_d    = opnd_q;
        data_d    = data_q;
        scnt_d    = '0;
        req_ready = '0;
`ifdef VAM_ARB_TIMEOUT_EN
        wd_d      = '0;
        err_d     = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Reset suppresses the grant so the accept pulse never escapes.
                if (pick_any && !rst) begin
                    req_ready[pick_idx] = 1'b1;
                    gnt_d   = pick_idx;
                    opnd_d  = req_opnd[int'(pick_idx) * VAM_DATA_W +: VAM_DATA_W];
`ifdef VAM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (scnt_q == SCNT_W'(START_CYC - 1)) begin
                    state_d = ST_RELEASE;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (vam_ready && !vrdy_prev_q) begin
                    data_d  = vam_rslt;
                    state_d = ST_RESP;
                end
`ifdef VAM_ARB_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            opnd_q      <= '0;
            data_q      <= '0;
            scnt_q      <= '0;
            vrdy_prev_q <= 1'b0;
`ifdef VAM_ARB_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            opnd_q      <= opnd_d;
            data_q      <= data_d;
            scnt_q      <= scnt_d;
            vrdy_prev_q <= vam_ready;
`ifdef VAM_ARB_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = gnt_q;
    assign rsp_data  = data_q;
    assign vam_start = (state_q == ST_START);
    assign vam_bus32 = (state_q == ST_IDLE) ? '0 : opnd_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef VAM_ARB_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire
